mem_bus_arbiter: RTL and testbench

- Sits directly downstream of the per-CPU dcache and icache blocks.
- Arbitrates their word-granular requests onto the single RAM port and returns data plus per-requester wait handshakes.
- Data requests take priority over instruction fetches. CPUs are served round-robin.
- A grant is locked across consecutive words of the same 8-byte block, so a dcache fetch1/fetch2 or wb1/wb2 pair is never interleaved with another requester.

---
 rtl/mem_bus_arbiter.sv | 227 ++++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: arbitrates per-CPU dcache/icache word requests onto one
// RAM port. Data requests beat instruction fetches, CPUs are served
// round-robin. A data grant is locked for a second word that falls in the
// same 8-byte block, so fetch1/fetch2 and wb1/wb2 pairs are never split.
//
// Ports:
//   CLK, nRST          clock (posedge) and synchronous active-low reset
//   dREN/dWEN/daddr/dstore  dcache requests, one lane per CPU
//   iREN/iaddr         icache requests, one lane per CPU
//   dwait/dload        dcache handshake (0 for one cycle per word) and data
//   iwait/iload        icache handshake and data
//   ramREN/ramWEN/ramaddr/ramstore/ramload/ramstate   single RAM port
//   bus_err            sticky RAM error / watchdog timeout flag
module mem_bus_arbiter #(
    parameter int CPUS    = 2,
    parameter int LAT_MAX = 15
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [CPUS-1:0]      dREN,
    input  logic [CPUS-1:0]      dWEN,
    input  logic [CPUS*32-1:0]   daddr,
    input  logic [CPUS*32-1:0]   dstore,
    input  logic [CPUS-1:0]      iREN,
    input  logic [CPUS*32-1:0]   iaddr,
    output logic [CPUS-1:0]      dwait,
    output logic [CPUS*32-1:0]   dload,
    output logic [CPUS-1:0]      iwait,
    output logic [CPUS*32-1:0]   iload,
    output logic                 ramREN,
    output logic                 ramWEN,
    output logic [31:0]          ramaddr,
    output logic [31:0]          ramstore,
    input  logic [31:0]          ramload,
    input  logic [1:0]           ramstate,
    output logic                 bus_err
);

    localparam int CW = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam logic [31:0] BAD_WORD = 32'hbad0_bad0;

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_DONE} state_t;
    typedef enum logic [1:0] {
        RAM_FREE = 2'd0, RAM_BUSY = 2'd1, RAM_ACCESS = 2'd2, RAM_ERROR = 2'd3
    } ramstate_t;

    // Modulo-CPUS wrap used for the round-robin search and pointer update.
    function automatic logic [CW-1:0] wrap(input int v);
        return CW'(v % CPUS);
    endfunction

    state_t         state_q,    state_d;
    logic [CW-1:0]  gnt_cpu_q,  gnt_cpu_d;
    logic           gnt_data_q, gnt_data_d;
    logic [CW-1:0]  rr_ptr_q,   rr_ptr_d;
    logic           lock_q,     lock_d;
    logic [28:0]    blk_q,      blk_d;
    logic [3:0]     wd_q,       wd_d;
    logic           bus_err_q,  bus_err_d;
    logic           fault_q,    fault_d;   // current DONE follows a fault

    logic [CPUS-1:0] d_req;
    logic            arb_found;
    logic [CW-1:0]   arb_cpu;
    logic            arb_data;

    logic            g_dren, g_dwen, g_req;
    logic [31:0]     g_daddr, g_dstore, g_iaddr;

    assign d_req   = dREN | dWEN;
    assign bus_err = bus_err_q;

    // Round-robin winner: any data request first, then any fetch, both
    // searched upward from rr_ptr_q.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        arb_found = 1'b0;
        arb_cpu   = rr_ptr_q;
        arb_data  = 1'b0;
        for (int i = 0; i < CPUS; i++) begin
            if (!arb_found && d_req[wrap(int'(rr_ptr_q) + i)]) begin
                arb_found = 1'b1;
                arb_data  = 1'b1;
                arb_cpu   = wrap(int'(rr_ptr_q) + i);
            end
        end
        for (int i = 0; i < CPUS; i++) begin
            if (!arb_found && iREN[wrap(int'(rr_ptr_q) + i)]) begin
                arb_found = 1'b1;
                arb_cpu   = wrap(int'(rr_ptr_q) + i);
            end
        end
    end

    // Live inputs of the currently granted port.
    always_comb begin
        g_dren   = dREN[gnt_cpu_q];
        g_dwen   = dWEN[gnt_cpu_q];
        g_daddr  = daddr[int'(gnt_cpu_q)*32 +: 32];
        g_dstore = dstore[int'(gnt_cpu_q)*32 +: 32];
        g_iaddr  = iaddr[int'(gnt_cpu_q)*32 +: 32];
        g_req    = gnt_data_q ? (g_dren | g_dwen) : iREN[gnt_cpu_q];
    end

    always_comb begin
        state_d    = state_q;
        gnt_cpu_d  = gnt_cpu_q;
        gnt_data_d = gnt_data_q;
        rr_ptr_d   = rr_ptr_q;
        lock_d     = lock_q;
        blk_d      = blk_q;
        wd_d       = wd_q;
        bus_err_d  = bus_err_q;
        fault_d    = fault_q;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        dwait      = '1;
        iwait      = '1;
        dload      = '0;
        iload      = '0;

        case (state_q)
            S_IDLE: begin
                lock_d  = 1'b0;
                fault_d = 1'b0;
                if (arb_found) begin
                    gnt_cpu_d  = arb_cpu;
                    gnt_data_d = arb_data;
                    blk_d      = daddr[int'(arb_cpu)*32 + 3 +: 29];
                    wd_d       = '0;
                    state_d    = S_GRANT;
                end
            end

            S_GRANT: begin
                if (!g_req) begin
                    // Requester withdrew before ACCESS: no transfer.
                    lock_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    if (gnt_data_q) begin
                        ramWEN   = g_dwen;
                        ramREN   = g_dren & ~g_dwen;   // write wins
                        ramaddr  = g_daddr;
                        ramstore = g_dstore;
                    end else begin
                        ramREN  = 1'b1;
                        ramaddr = g_iaddr;
                    end

                    if (ramstate == RAM_ERROR || wd_q == 4'(LAT_MAX)) begin
                        // Release the requester with a poison word.
                        bus_err_d = 1'b1;
                        fault_d   = 1'b1;
                        state_d   = S_DONE;
                        if (gnt_data_q) begin
                            dwait[gnt_cpu_q]                  = 1'b0;
                            dload[int'(gnt_cpu_q)*32 +: 32]   = BAD_WORD;
                        end else begin
                            iwait[gnt_cpu_q]                  = 1'b0;
                            iload[int'(gnt_cpu_q)*32 +: 32]   = BAD_WORD;
                        end
                    end else if (ramstate == RAM_ACCESS) begin
                        state_d = S_DONE;
                        if (gnt_data_q) begin
                            dwait[gnt_cpu_q] = 1'b0;
                            if (!g_dwen) dload[int'(gnt_cpu_q)*32 +: 32] = ramload;
                        end else begin
                            iwait[gnt_cpu_q]                = 1'b0;
                            iload[int'(gnt_cpu_q)*32 +: 32] = ramload;
                        end
                    end else begin
                        wd_d = wd_q + 4'd1;
                    end
                end
            end

            S_DONE: begin
                fault_d = 1'b0;
                // Second word of the same block keeps the grant; a third
                // word, or any word after a fault, goes back to arbitration.
                if (gnt_data_q && !lock_q && !fault_q && (g_dren | g_dwen)
                    && g_daddr[31:3] == blk_q) begin
                    lock_d  = 1'b1;
                    wd_d    = '0;
                    state_d = S_GRANT;
                end else begin
                    lock_d   = 1'b0;
                    rr_ptr_d = wrap(int'(gnt_cpu_q) + 1);
                    state_d  = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!nRST) begin
            state_q    <= S_IDLE;
            gnt_cpu_q  <= '0;
            gnt_data_q <= 1'b0;
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            blk_q      <= '0;
            wd_q       <= '0;
            bus_err_q  <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_cpu_q  <= gnt_cpu_d;
            gnt_data_q <= gnt_data_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_q     <= lock_d;
            blk_q      <= blk_d;
            wd_q       <= wd_d;
            bus_err_q  <= bus_err_d;
            fault_q    <= fault_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter (CPUS=2). Inputs change 1 time unit
// after each rising edge; outputs are sampled 1 unit later.
module tb_mem_bus_arbiter;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [1:0]  dREN, dWEN, iREN;
    logic [63:0] daddr, dstore, iaddr;
    logic [1:0]  dwait, iwait;
    logic [63:0] dload, iload;
    logic        ramREN, ramWEN;
    logic [31:0] ramaddr, ramstore, ramload;
    logic [1:0]  ramstate;
    logic        bus_err;

    int checks   = 0;
    int failures = 0;
    int cpu_e, word_e;

    mem_bus_arbiter #(.CPUS(2), .LAT_MAX(15)) dut (
        .CLK(CLK), .nRST(nRST),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .iREN(iREN), .iaddr(iaddr),
        .dwait(dwait), .dload(dload), .iwait(iwait), .iload(iload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
        .bus_err(bus_err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] addr_of(input int c, input int w);
        return 32'h1000 + 32'(c) * 32'h1000 + 32'(w) * 32'h10;
    endfunction

    function automatic logic [31:0] data_of(input int c, input int w);
        return 32'hA000_0000 | (32'(c) << 16) | 32'(w);
    endfunction

    initial begin
        nRST = 1'b0; dREN = '0; dWEN = '0; iREN = '0;
        daddr = '0; dstore = '0; iaddr = '0; ramload = '0; ramstate = 2'd0;
        tick(); tick();
        check("rst_ramREN",   ramREN,   0);
        check("rst_ramWEN",   ramWEN,   0);
        check("rst_ramaddr",  ramaddr,  0);
        check("rst_ramstore", ramstore, 0);
        check("rst_dwait",    dwait,    2'b11);
        check("rst_iwait",    iwait,    2'b11);
        check("rst_dload",    dload,    0);
        check("rst_iload",    iload,    0);
        check("rst_bus_err",  bus_err,  0);
        nRST = 1'b1;
        tick();

        // Single read from CPU0, ACCESS on the second GRANT cycle.
        dREN = 2'b01; daddr[31:0] = 32'h40; ramstate = 2'd1; #1;
        check("t1_arb_ramREN", ramREN, 0);
        tick();
        check("t1_g1_ramREN", ramREN, 1);
        check("t1_g1_ramaddr", ramaddr, 32'h40);
        check("t1_g1_dwait", dwait, 2'b11);
        tick();
        ramstate = 2'd2; ramload = 32'hDEADBEEF; #1;
        check("t1_acc_dwait", dwait, 2'b10);
        check("t1_acc_dload", dload[31:0], 32'hDEADBEEF);
        check("t1_acc_iwait", iwait, 2'b11);
        tick();
        dREN = 2'b00; ramstate = 2'd0; #1;
        check("t1_done_dwait", dwait, 2'b11);
        check("t1_done_ramREN", ramREN, 0);
        tick();
        check("t1_idle_ramREN", ramREN, 0);

        // Locked 2-word fetch from CPU0 while CPU1 icache waits; a third
        // matching word must not stay locked.
        dREN = 2'b01; daddr[31:0] = 32'h40; iREN = 2'b10; iaddr[63:32] = 32'h100;
        ramstate = 2'd2; ramload = 32'h11111111; #1;
        tick();
        check("t2_w1_ramaddr", ramaddr, 32'h40);
        check("t2_w1_dwait", dwait, 2'b10);
        check("t2_w1_dload", dload[31:0], 32'h11111111);
        check("t2_w1_iwait", iwait, 2'b11);
        tick();
        daddr[31:0] = 32'h44; ramstate = 2'd0; #1;
        check("t2_d1_dwait", dwait, 2'b11);
        tick();
        ramstate = 2'd2; ramload = 32'h22222222; #1;
        check("t2_w2_ramREN", ramREN, 1);
        check("t2_w2_ramaddr", ramaddr, 32'h44);
        check("t2_w2_dwait", dwait, 2'b10);
        check("t2_w2_dload", dload[31:0], 32'h22222222);
        check("t2_w2_iwait", iwait, 2'b11);
        tick();
        daddr[31:0] = 32'h40; ramstate = 2'd0; #1;
        check("t2_d2_dwait", dwait, 2'b11);
        tick();
        dREN = 2'b00; ramstate = 2'd2; ramload = 32'h33333333; #1;
        check("t2_third_rearb_ramREN", ramREN, 0);
        tick();
        check("t2_i_ramaddr", ramaddr, 32'h100);
        check("t2_i_iwait", iwait, 2'b01);
        check("t2_i_iload", iload[63:32], 32'h33333333);
        check("t2_i_dwait", dwait, 2'b11);
        tick();
        iREN = 2'b00; #1;
        tick();

        // Both CPUs write every cycle (CPU1 also holds dREN): strict alternation.
        dWEN = 2'b11; dREN = 2'b10; ramstate = 2'd2;
        daddr[31:0] = addr_of(0, 0);  dstore[31:0] = data_of(0, 0);
        daddr[63:32] = addr_of(1, 0); dstore[63:32] = data_of(1, 0);
        #1;
        for (int k = 0; k < 8; k++) begin
            cpu_e = k % 2; word_e = k / 2;
            check("t3_idle_ramWEN", ramWEN, 0);
            tick();
            check("t3_ramWEN", ramWEN, 1);
            check("t3_ramREN", ramREN, 0);
            check("t3_ramaddr", ramaddr, addr_of(cpu_e, word_e));
            check("t3_ramstore", ramstore, data_of(cpu_e, word_e));
            check("t3_dwait", dwait, (cpu_e == 0) ? 2'b10 : 2'b01);
            tick();
            if (word_e < 3) begin
                daddr[cpu_e*32 +: 32]  = addr_of(cpu_e, word_e + 1);
                dstore[cpu_e*32 +: 32] = data_of(cpu_e, word_e + 1);
            end else begin
                dWEN[cpu_e] = 1'b0; dREN[cpu_e] = 1'b0;
            end
            #1;
            check("t3_done_dwait", dwait, 2'b11);
            tick();
        end

        // CPU1 dcache and icache together: dcache first.
        dREN = 2'b10; daddr[63:32] = 32'h300; iREN = 2'b10; iaddr[63:32] = 32'h400;
        ramstate = 2'd2; ramload = 32'h44444444; #1;
        check("t4_arb_ramREN", ramREN, 0);
        tick();
        check("t4_d_ramaddr", ramaddr, 32'h300);
        check("t4_d_dwait", dwait, 2'b01);
        check("t4_d_dload", dload[63:32], 32'h44444444);
        check("t4_d_iwait", iwait, 2'b11);
        tick();
        dREN = 2'b00; #1;
        check("t4_done_iwait", iwait, 2'b11);
        tick();
        ramload = 32'h55555555; #1;
        check("t4_idle_iwait", iwait, 2'b11);
        tick();
        check("t4_i_ramaddr", ramaddr, 32'h400);
        check("t4_i_iwait", iwait, 2'b01);
        check("t4_i_iload", iload[63:32], 32'h55555555);
        tick();
        iREN = 2'b00; #1;
        tick();

        // Watchdog: RAM stays BUSY; 15 wait cycles then a poison pulse.
        dREN = 2'b01; daddr[31:0] = 32'h500; ramstate = 2'd1; #1;
        tick();
        for (int k = 0; k < 15; k++) begin
            check("t5_hold_dwait", dwait, 2'b11);
            tick();
        end
        check("t5_to_dwait", dwait, 2'b10);
        check("t5_to_dload", dload[31:0], 32'hbad0bad0);
        check("t5_to_bus_err_pre", bus_err, 0);
        tick();
        daddr[31:0] = 32'h504; #1;
        check("t5_done_bus_err", bus_err, 1);
        check("t5_done_dwait", dwait, 2'b11);
        tick();
        dREN = 2'b00; #1;
        check("t5_nolock_ramREN", ramREN, 0);
        check("t5_sticky_bus_err", bus_err, 1);
        ramstate = 2'd0;
        tick();

        // Reset while a read is in GRANT.
        dREN = 2'b01; daddr[31:0] = 32'h600; ramstate = 2'd1; #1;
        tick();
        check("t6_grant_ramREN", ramREN, 1);
        nRST = 1'b0;
        tick();
        nRST = 1'b1; #1;
        check("t6_rst_ramREN", ramREN, 0);
        check("t6_rst_dwait", dwait, 2'b11);
        check("t6_rst_iwait", iwait, 2'b11);
        check("t6_rst_bus_err", bus_err, 0);
        tick();
        check("t6_regrant_ramREN", ramREN, 1);
        ramstate = 2'd2; ramload = 32'h66666666; #1;
        check("t6_regrant_dwait", dwait, 2'b10);
        check("t6_regrant_dload", dload[31:0], 32'h66666666);
        tick();
        dREN = 2'b00; ramstate = 2'd0; #1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
